adc_sample_controller: RTL and testbench

- Sequences the serial ADC front end.
- Generates CS and SCLK for the shift-register receiver from the system clock, either at a programmed sample rate or on single-shot request.
- Adds trailing clock edges so the receiver returns to idle, then latches the receiver's parallel output and issues a one-cycle sample strobe.
- Sits between the ADC pins/receiver and the downstream DSP/display logic.

---
 rtl/adc_sample_controller_pkg.sv | 32 +++
 rtl/adc_rate_timer.sv | 34 +++
 rtl/adc_sample_controller.sv | 214 +++++++++++++++++++++
 tb/tb_adc_sample_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sample_controller_pkg.sv
// Shared definitions for the ADC sample controller: FSM state encoding,
// default timing constants and derived frame-length constants.
package adc_sample_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_TAIL    = 3'd4,
    ST_LATCH   = 3'd5,
    ST_QUIET   = 3'd6
  } state_t;

  localparam int DEF_CLK_DIV       = 4;
  localparam int DEF_FRAME_BITS    = 16;
  localparam int DEF_TAIL_PERIODS  = 2;
  localparam int DEF_QUIET_CYCLES  = 8;
  localparam int DEF_SAMPLE_PERIOD = 2000;
  localparam int DEF_DATA_W        = 16;

  // clk cycles with CS low: setup half-period, FRAME_BITS full periods, release half-period
  function automatic int cs_low_cycles(input int clk_div, input int frame_bits);
    return clk_div * (2 * frame_bits + 2);
  endfunction

  localparam int DEF_CS_LOW_CYCLES = cs_low_cycles(DEF_CLK_DIV, DEF_FRAME_BITS);
  localparam int DEF_TAIL_CYCLES   = 2 * DEF_CLK_DIV * DEF_TAIL_PERIODS;
  // busy cycles per frame: CS low + tail + latch + quiet
  localparam int DEF_FRAME_CYCLES  = DEF_CS_LOW_CYCLES + DEF_TAIL_CYCLES + 1 + DEF_QUIET_CYCLES;

endpackage

// File: rtl/adc_rate_timer.sv
// Free-run sample-rate timer: counts 0..SAMPLE_PERIOD-1 while enabled,
// pulses tick on the wrap cycle, and is held at zero while disabled.
module adc_rate_timer
  import adc_sample_controller_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] count_reg;
  logic             wrap;

  assign wrap = (count_reg == CNT_LAST);
  assign tick = enable & wrap;

  // Period counter; cleared by reset and whenever free-run is disabled
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (!enable || wrap) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_sample_controller.sv
// Serial ADC frame sequencer: generates CS/SCLK for the shift-register
// receiver, adds trailing SCLK periods, latches the parallel word and
// strobes sample_valid. Optional build macro ADC_AVG4_EN replaces the raw
// word with the arithmetic mean of four consecutive frames.
module adc_sample_controller
  import adc_sample_controller_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int FRAME_BITS    = DEF_FRAME_BITS,
  parameter int TAIL_PERIODS  = DEF_TAIL_PERIODS,
  parameter int QUIET_CYCLES  = DEF_QUIET_CYCLES,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
  parameter int DATA_W        = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              overrun_clr,
  input  logic [DATA_W-1:0] adc_data,
  output logic              CS,
  output logic              SCLK,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_MAX  = (QUIET_CYCLES > CLK_DIV) ? QUIET_CYCLES : CLK_DIV;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int HALF_MAX = 2 * ((FRAME_BITS > TAIL_PERIODS) ? FRAME_BITS : TAIL_PERIODS);
  localparam int HALF_W   = $clog2(HALF_MAX + 1);

  localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [HALF_W-1:0] SHIFT_LAST = HALF_W'(2 * FRAME_BITS - 1);
  localparam logic [HALF_W-1:0] TAIL_LAST  = HALF_W'(2 * TAIL_PERIODS - 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;     // cycles within a half-period / quiet gap
  logic [HALF_W-1:0]   half_reg, half_next;   // half-period index; odd = SCLK high
  logic                cs_reg, cs_next;
  logic                sclk_reg, sclk_next;
  logic                busy_reg, busy_next;
  logic [DATA_W-1:0]   sample_reg;
  logic                sample_valid_reg;
  logic                overrun_reg;
  logic                timer_tick;
  logic                trig;

  adc_rate_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_rate_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (timer_tick)
  );

  assign trig = start | (enable & timer_tick);

  // Next-state logic; pin levels are decoded from the next state so CS/SCLK come straight from flops
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    half_next  = half_reg;
    unique case (state_reg)
      ST_IDLE: begin
        cnt_next  = '0;
        half_next = '0;
        if (trig) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next   = '0;
          half_next  = '0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (half_reg == SHIFT_LAST) begin
            half_next  = '0;
            state_next = ST_RELEASE;
          end else begin
            half_next = half_reg + HALF_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next   = '0;
          half_next  = '0;
          state_next = ST_TAIL;
        end
      end
      ST_TAIL: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (half_reg == TAIL_LAST) begin
            half_next  = '0;
            state_next = ST_LATCH;
          end else begin
            half_next = half_reg + HALF_W'(1);
          end
        end
      end
      ST_LATCH: begin
        cnt_next   = '0;
        state_next = ST_QUIET;
      end
      ST_QUIET: begin
        if (cnt_reg == QUIET_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        half_next  = '0;
        state_next = ST_IDLE;
      end
    endcase

    cs_next   = !((state_next == ST_SETUP) || (state_next == ST_SHIFT) || (state_next == ST_RELEASE));
    sclk_next = 1'b1;
    if ((state_next == ST_SHIFT) || (state_next == ST_TAIL)) sclk_next = half_next[0];
    busy_next = (state_next != ST_IDLE);
  end

  // State, counters and registered pin outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      half_reg  <= '0;
      cs_reg    <= 1'b1;
      sclk_reg  <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      half_reg  <= half_next;
      cs_reg    <= cs_next;
      sclk_reg  <= sclk_next;
      busy_reg  <= busy_next;
    end
  end

  // Sticky overrun: a dropped trigger sets it, and setting beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_reg <= 1'b0;
    end else if (trig && (state_reg != ST_IDLE)) begin
      overrun_reg <= 1'b1;
    end else if (overrun_clr) begin
      overrun_reg <= 1'b0;
    end
  end

`ifdef ADC_AVG4_EN
  logic signed [DATA_W+1:0] acc_reg;
  logic signed [DATA_W+1:0] acc_sum;
  logic [1:0]               phase_reg;

  assign acc_sum = acc_reg + $signed({{2{adc_data[DATA_W-1]}}, adc_data});

  // Accumulate four latched words and publish their arithmetic mean on the fourth
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_reg          <= '0;
      phase_reg        <= '0;
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (state_reg == ST_LATCH) begin
        if (phase_reg == 2'd3) begin
          sample_reg       <= acc_sum[DATA_W+1:2];
          sample_valid_reg <= 1'b1;
          acc_reg          <= '0;
          phase_reg        <= '0;
        end else begin
          acc_reg   <= acc_sum;
          phase_reg <= phase_reg + 2'd1;
        end
      end
    end
  end
`else
  // Capture the receiver word once per frame and strobe it downstream
  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_reg       <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (state_reg == ST_LATCH) begin
        sample_reg       <= adc_data;
        sample_valid_reg <= 1'b1;
      end
    end
  end
`endif

  assign CS           = cs_reg;
  assign SCLK         = sclk_reg;
  assign busy         = busy_reg;
  assign sample       = sample_reg;
  assign sample_valid = sample_valid_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_adc_sample_controller.sv
// Directed bench for adc_sample_controller: frame timing, free-run rate,
// overrun handling, mid-frame reset and (with ADC_AVG4_EN) 4-frame averaging.
module tb_adc_sample_controller;
  import adc_sample_controller_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, start, overrun_clr;
  logic [15:0] adc_data;
  logic        CS, SCLK, sample_valid, busy, overrun;
  logic [15:0] sample;

  logic        enable_f, start_f, clr_f;
  logic        cs_f, sclk_f, valid_f, busy_f, ovr_f;
  logic [15:0] sample_f;

  int total_cnt = 0;
  int bad_cnt   = 0;

  int   cs_low, rise_low, rise_high, valid_cnt, valid_dly;
  bit   done;
  int   falls, rises, vsum;
  logic prev_cs, prev_sclk;
  int   fall_t[8];

  always #5 clk = ~clk;

  adc_sample_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .overrun_clr(overrun_clr),
    .adc_data(adc_data), .CS(CS), .SCLK(SCLK), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  adc_sample_controller #(.SAMPLE_PERIOD(100)) dut_fast (
    .clk(clk), .reset(reset), .enable(enable_f), .start(start_f), .overrun_clr(clr_f),
    .adc_data(adc_data), .CS(cs_f), .SCLK(sclk_f), .sample(sample_f),
    .sample_valid(valid_f), .busy(busy_f), .overrun(ovr_f)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where CS was first seen low; follows the frame until busy drops
  task automatic measure_frame(output int n_low, output int r_low, output int r_high,
                               output int v_cnt, output int v_dly, output bit fin);
    int   rise_at;
    logic p_sclk, p_cs;
    n_low = 0; r_low = 0; r_high = 0; v_cnt = 0; v_dly = -1; fin = 1'b0;
    rise_at = -1; p_sclk = 1'b1; p_cs = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i > 0) @(negedge clk);
      if (!CS) n_low++;
      if (SCLK && !p_sclk) begin
        if (!CS) r_low++;
        else     r_high++;
      end
      if (CS && !p_cs && rise_at < 0) rise_at = i;
      if (sample_valid) begin
        v_cnt++;
        v_dly = i - rise_at;
      end
      p_sclk = SCLK;
      p_cs   = CS;
      if (!busy) begin
        fin = 1'b1;
        break;
      end
    end
    $display("frame: cs_low=%0d rises_low=%0d rises_tail=%0d valids=%0d valid_after_cs_rise=%0d sample=0x%04h",
             n_low, r_low, r_high, v_cnt, v_dly, sample);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] word);
    adc_data = word;
    pulse_start();
    measure_frame(cs_low, rise_low, rise_high, valid_cnt, valid_dly, done);
    check_val("frame_done", int'(done), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, int'(busy), 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; start = 1'b0; overrun_clr = 1'b0; adc_data = 16'h0ABC;
    enable_f = 1'b0; start_f = 1'b0; clr_f = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_cs", int'(CS), 1);
    check_val("rst_sclk", int'(SCLK), 1);
    check_val("rst_sample", int'(sample), 0);
    check_val("rst_valid", int'(sample_valid), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_overrun", int'(overrun), 0);
    reset = 1'b1;
    @(negedge clk);

    // Single-shot frame
    adc_data = 16'h0ABC;
    pulse_start();
    check_val("cs_fall_latency", int'(CS), 0);
    measure_frame(cs_low, rise_low, rise_high, valid_cnt, valid_dly, done);
    check_val("frame_done", int'(done), 1);
    check_val("cs_low_len", cs_low, DEF_CS_LOW_CYCLES);
    check_val("rises_cs_low", rise_low, 16);
    check_val("rises_tail", rise_high, 2);
`ifdef ADC_AVG4_EN
    check_val("avg_no_early_valid", valid_cnt, 0);
`else
    check_val("valid_count", valid_cnt, 1);
    check_val("valid_delay", valid_dly, 17);
    check_val("sample_word", int'(sample), 16'h0ABC);
`endif
    check_val("overrun_single", int'(overrun), 0);

    // Free-run at SAMPLE_PERIOD=2000 for 10000 clk
    enable = 1'b1; falls = 0; prev_cs = CS;
    for (int i = 1; i <= 10000; i++) begin
      @(negedge clk);
      if (!CS && prev_cs) begin
        if (falls < 8) fall_t[falls] = i;
        falls++;
      end
      prev_cs = CS;
    end
    enable = 1'b0;
    $display("free-run: frames=%0d first_fall=%0d", falls, fall_t[0]);
    check_val("freerun_frames", falls, 5);
    for (int k = 1; k < 5; k++) check_val("freerun_gap", fall_t[k] - fall_t[k-1], 2000);
    check_val("freerun_overrun", int'(overrun), 0);
    wait_idle("freerun_finish");
    falls = 0; prev_cs = CS;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (!CS && prev_cs) falls++;
      prev_cs = CS;
    end
    check_val("no_tick_after_disable", falls, 0);

    // start coinciding with timer tick
    enable = 1'b1;
    repeat (1999) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    falls = 0; prev_cs = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge clk);
      if (!CS && prev_cs) falls++;
      prev_cs = CS;
    end
    enable = 1'b0;
    $display("start+tick: frames=%0d overrun=%0d", falls, overrun);
    check_val("start_tick_frames", falls, 1);
    check_val("start_tick_overrun", int'(overrun), 0);

    // start during QUIET is dropped
    pulse_start();
    for (int i = 0; i < 300 && !CS; i++) @(negedge clk);
    repeat (19) @(negedge clk);
    pulse_start();
    $display("start in quiet: busy=%0d overrun=%0d", busy, overrun);
    check_val("quiet_busy", int'(busy), 1);
    check_val("quiet_overrun", int'(overrun), 1);
    wait_idle("quiet_finish");
    falls = 0; prev_cs = CS;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!CS && prev_cs) falls++;
      prev_cs = CS;
    end
    check_val("quiet_start_dropped", falls, 0);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check_val("overrun_cleared", int'(overrun), 0);

    // SAMPLE_PERIOD=100: every second tick overruns
    enable_f = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      clr_f = (i == 205 || i == 450 || i == 599);
      if (i == 198) check_val("fast_ovr_before", int'(ovr_f), 0);
      if (i == 200) check_val("fast_ovr_set", int'(ovr_f), 1);
      if (i == 206) check_val("fast_ovr_clr", int'(ovr_f), 0);
      if (i == 398) check_val("fast_ovr_held0", int'(ovr_f), 0);
      if (i == 400) check_val("fast_ovr_reset", int'(ovr_f), 1);
      if (i == 451) check_val("fast_ovr_clr2", int'(ovr_f), 0);
      if (i == 600) check_val("fast_set_wins", int'(ovr_f), 1);
    end
    clr_f = 1'b0; enable_f = 1'b0;
    $display("fast timer: overrun=%0d", ovr_f);

    // Reset at the 8th SCLK rising edge
    pulse_start();
    rises = 0; prev_sclk = SCLK;
    for (int i = 0; i < 200 && rises < 8; i++) begin
      @(negedge clk);
      if (SCLK && !prev_sclk) rises++;
      prev_sclk = SCLK;
    end
    check_val("abort_rises", rises, 8);
    reset = 1'b0;
    @(negedge clk);
    $display("abort: cs=%0d sclk=%0d busy=%0d valid=%0d", CS, SCLK, busy, sample_valid);
    check_val("abort_cs", int'(CS), 1);
    check_val("abort_sclk", int'(SCLK), 1);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_valid", int'(sample_valid), 0);
    check_val("abort_sample", int'(sample), 0);
    reset = 1'b1;
    vsum = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_valid) vsum++;
    end
    check_val("abort_no_strobe", vsum, 0);
    run_frame(16'h1234);
    check_val("restart_cs_low", cs_low, DEF_CS_LOW_CYCLES);
    check_val("restart_rises", rise_low, 16);

`ifdef ADC_AVG4_EN
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vsum = 0;
    run_frame(16'h0010); vsum += valid_cnt;
    run_frame(16'h0020); vsum += valid_cnt;
    run_frame(16'h0030); vsum += valid_cnt;
    run_frame(16'h0040); vsum += valid_cnt;
    check_val("avg_pos_valids", vsum, 1);
    check_val("avg_pos_sample", int'(sample), 16'h0028);
    vsum = 0;
    run_frame(16'hFFF0); vsum += valid_cnt;
    run_frame(16'hFFF0); vsum += valid_cnt;
    run_frame(16'hFFF0); vsum += valid_cnt;
    run_frame(16'hFFF4); vsum += valid_cnt;
    check_val("avg_neg_valids", vsum, 1);
    check_val("avg_neg_sample", int'(sample), 16'hFFF1);
`else
    check_val("raw_sample_1234", int'(sample), 16'h1234);
    run_frame(16'hF00D);
    check_val("raw_valids", valid_cnt, 1);
    check_val("raw_sample_f00d", int'(sample), 16'hF00D);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
